// File: rtl/jtframe_ps2_keymap.sv
// PS/2 keyboard front end: synchronised and filtered line receiver, E0/F0/E1 prefix
// decoding and a 512-entry programmable map that drives a flat key-state vector.
module jtframe_ps2_keymap #(
    parameter int NKEYS   = 64,
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 16384
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             prog_we,
    input  logic [8:0]       prog_addr,
    input  logic [7:0]       prog_data,
    output logic             ready,
    output logic [NKEYS-1:0] key_state,
    output logic             key_pause,
    output logic [7:0]       rx_byte,
    output logic             rx_valid,
    output logic             rx_err
);
    localparam int IW = $clog2(NKEYS);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0] NK = NKEYS[IW:0];

    typedef enum logic {S_INIT, S_RUN} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic [FW-1:0] flt_cnt;
    logic          flt_clk, flt_clk_d, fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic [10:0]   frame;
    logic [TW-1:0] to_cnt;

    // The line idles high, so the synchronisers and filter reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            flt_cnt   <= '0;
            flt_clk   <= 1'b1;
            flt_clk_d <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_data};
            flt_clk_d <= flt_clk;
            if (clk_sync[1] == flt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER - 1)) begin
                flt_clk <= clk_sync[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    assign fall  = flt_clk_d & ~flt_clk;
    // frame[0] start, frame[8:1] data, frame[9] parity, frame[10] stop
    assign frame = {dat_sync[1], shift};

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            shift    <= '0;
            to_cnt   <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!frame[0] && frame[10] && (^frame[9:1])) begin
                        rx_byte  <= frame[8:1];
                        rx_valid <= 1'b1;
                    end else begin
                        rx_err <= 1'b1;
                    end
                end else begin
                    shift   <= {dat_sync[1], shift[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TW'(TIMEOUT - 1)) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                    rx_err  <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end

    state_t        state;
    logic [8:0]    init_addr;
    logic [7:0]    map_mem [512];
    logic          ext, rel, rel_l, apply, rd_valid;
    logic [IW-1:0] rd_idx;
    logic [2:0]    pause_cnt;
    logic          mem_we, lookup;
    logic [8:0]    mem_addr, look_addr;
    logic [7:0]    mem_din;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = prog_addr;
        mem_din  = prog_data;
        if (!rst) begin
            if (state == S_INIT) begin
                mem_we   = 1'b1;
                mem_addr = init_addr;
                mem_din  = 8'h00;
            end else begin
                mem_we = prog_we;
            end
        end
    end

    assign lookup = (state == S_RUN) && rx_valid && (pause_cnt == 3'd0) &&
                    (rx_byte != 8'hE0) && (rx_byte != 8'hF0) && (rx_byte != 8'hE1);
    assign look_addr = {ext, rx_byte};

    // Read-before-write: a same-cycle write and lookup sees the old entry.
    always_ff @(posedge clk) begin
        if (mem_we) map_mem[mem_addr] <= mem_din;
        if (lookup) begin
            rd_valid <= map_mem[look_addr][7];
            rd_idx   <= map_mem[look_addr][IW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            init_addr <= '0;
            ready     <= 1'b0;
            ext       <= 1'b0;
            rel       <= 1'b0;
            rel_l     <= 1'b0;
            apply     <= 1'b0;
            pause_cnt <= '0;
            key_pause <= 1'b0;
            key_state <= '0;
        end else begin
            apply <= 1'b0;
            case (state)
                S_INIT: begin
                    init_addr <= init_addr + 9'd1;
                    if (init_addr == 9'd511) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (rx_err) begin
                        ext <= 1'b0;
                        rel <= 1'b0;
                    end else if (rx_valid) begin
                        if (pause_cnt != 3'd0) begin
                            pause_cnt <= pause_cnt - 3'd1;
                            if (pause_cnt == 3'd1) key_pause <= ~key_pause;
                        end else begin
                            case (rx_byte)
                                8'hE0:   ext <= 1'b1;
                                8'hF0:   rel <= 1'b1;
                                8'hE1:   pause_cnt <= 3'd7;
                                default: begin
                                    apply <= 1'b1;
                                    rel_l <= rel;
                                    ext   <= 1'b0;
                                    rel   <= 1'b0;
                                end
                            endcase
                        end
                    end
                    if (apply && rd_valid && ({1'b0, rd_idx} < NK)) key_state[rd_idx] <= ~rel_l;
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule
